// File: rtl/lsu_ctrl.sv
// lsu_ctrl: MEM-stage load/store sequencer driving one word-aligned transaction per
// instruction on a variable-latency data port. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        lsu_done,
  output logic [31:0] load_data,
  output logic        bus_err,
  output logic        misalign
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        store_q, store_d;
  logic [31:0] word_q, word_d;
  logic        err_q, err_d;
  logic        mis_q, mis_d;

  logic [1:0]  off;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic        trap;

  assign off = ALUResultM[1:0];

  // Byte enables and lane-replicated data for the incoming store.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    st_be    = 4'b0000;
    st_wdata = 32'h0;
    case (funct3M)
      F3_B: begin
        st_be    = 4'b0001 << off;
        st_wdata = {4{WriteDataM[7:0]}};
      end
      F3_H: begin
        st_be    = 4'b0011 << {off[1], 1'b0};
        st_wdata = {2{WriteDataM[15:0]}};
      end
      F3_W: begin
        st_be    = 4'b1111;
        st_wdata = WriteDataM;
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic is_half, is_word;
  assign is_half = (funct3M == F3_H) || (!MemWriteM && (funct3M == F3_HU));
  assign is_word = (funct3M == F3_W);
  assign trap    = MemReqM && ((is_half && off[0]) || (is_word && (off != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  function automatic logic [31:0] loadext(input logic [2:0]  f3,
                                          input logic [1:0]  lo,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'h0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'h0, h};
      F3_W:    r = w;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    store_d = store_q;
    word_d  = word_q;
    err_d   = err_q;
    mis_d   = mis_q;

    case (state_q)
      IDLE: begin
        if (MemReqM && trap) begin
          state_d = DONE;
          store_d = MemWriteM;
          word_d  = 32'h0;
          err_d   = 1'b0;
          mis_d   = 1'b1;
        end else if (MemReqM) begin
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = MemWriteM;
          addr_d  = {ALUResultM[31:2], 2'b00};
          be_d    = MemWriteM ? st_be : 4'b1111;
          wdata_d = MemWriteM ? st_wdata : 32'h0;
          f3_d    = funct3M;
          off_d   = off;
          store_d = MemWriteM;
          cnt_d   = 8'd0;
          word_d  = 32'h0;
          err_d   = 1'b0;
          mis_d   = 1'b0;
        end
      end
      BUSY: begin
        if (dmem_ready) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!store_q) word_d = dmem_rdata;
        end else if (cnt_q == CntLast) begin
          // The memory never answered: abort and report a bus error with zeroed data.
          state_d = DONE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          word_d  = 32'h0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        // MemReqM is still asserted for the finished instruction, so it is not re-examined here.
        state_d = IDLE;
        err_d   = 1'b0;
        mis_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the synchronous reset clears the data path too, so every output is zero right after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      store_q <= 1'b0;
      word_q  <= 32'h0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      store_q <= store_d;
      word_q  <= word_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

  assign StallM    = ((state_q == IDLE) && MemReqM && !trap) || (state_q == BUSY);
  assign lsu_done  = (state_q == DONE);
  assign bus_err   = err_q;
  assign load_data = (lsu_done && !store_q && !mis_q) ? loadext(f3_q, off_q, word_q) : 32'h0;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = mis_q;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized and directed checks of lsu_ctrl against a behavioural model
// of its access timing, byte-lane encoding and load extension.
module tb_lsu_ctrl;

  localparam int TIMEOUT = 16;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TrapOn = 1'b1;
`else
  localparam bit TrapOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemReqM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        StallM, lsu_done;
  logic [31:0] load_data;
  logic        bus_err, misalign;

  int tests_run    = 0;
  int tests_failed = 0;

  lsu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemReqM    (MemReqM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .StallM     (StallM),
    .lsu_done   (lsu_done),
    .load_data  (load_data),
    .bus_err    (bus_err),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: access rules expressed with plain arithmetic.
  function automatic bit model_misaligned(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int unsigned o;
    bit half, word;
    o    = addr % 4;
    half = (f3 == 3'd1) || (!we && f3 == 3'd5);
    word = (f3 == 3'd2);
    return TrapOn && ((half && (o % 2 != 0)) || (word && o != 0));
  endfunction

  function automatic void model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                                      output logic [3:0] be, output logic [31:0] wdata);
    int unsigned o;
    o = addr % 4;
    case (f3)
      3'd0: begin be = 4'(1 << o);           wdata = (wd & 32'hFF) * 32'h01010101; end
      3'd1: begin be = 4'(3 << ((o / 2) * 2)); wdata = (wd & 32'hFFFF) * 32'h00010001; end
      3'd2: begin be = 4'hF;                  wdata = wd; end
      default: begin be = 4'h0;               wdata = 32'h0; end
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] w);
    int unsigned o;
    longint v;
    o = addr % 4;
    case (f3)
      3'd0, 3'd4: begin
        v = longint'((w >> (8 * o)) & 32'hFF);
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = longint'((w >> (16 * (o / 2))) & 32'hFFFF);
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      3'd2:    v = longint'(w);
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  // One complete access; caller is positioned just after a rising edge with the LSU idle.
  task automatic do_access(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int waits, input logic [31:0] rdata);
    bit          trap, timed_out, busy, e_stall, e_req, e_done;
    int          done_cyc;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_load;
    trap      = model_misaligned(we, f3, addr);
    timed_out = !trap && (waits >= TIMEOUT);
    done_cyc  = trap ? 1 : (timed_out ? TIMEOUT + 1 : waits + 2);
    if (we) model_store(f3, addr, wd, e_be, e_wdata);
    else begin e_be = 4'hF; e_wdata = 32'h0; end
    e_load = (trap || we || timed_out) ? 32'h0 : model_load(f3, addr, rdata);

    for (int cyc = 0; cyc <= done_cyc; cyc++) begin
      busy       = !trap && cyc >= 1 && cyc < done_cyc;
      MemReqM    = 1'b1;
      MemWriteM  = we;
      funct3M    = f3;
      ALUResultM = addr;
      WriteDataM = wd;
      if (busy) dmem_ready = !timed_out && (cyc == waits + 1);
      else      dmem_ready = 1'($urandom_range(0, 1));
      dmem_rdata = (busy && dmem_ready) ? rdata : $urandom;
      @(negedge clk);
      e_stall = !trap && cyc < done_cyc;
      e_req   = busy;
      e_done  = (cyc == done_cyc);
      tests_run++;
      if (StallM !== e_stall) begin
        tests_failed++;
        $display("FAIL %s cyc%0d StallM got %b exp %b", tag, cyc, StallM, e_stall);
      end
      tests_run++;
      if (dmem_req !== e_req) begin
        tests_failed++;
        $display("FAIL %s cyc%0d dmem_req got %b exp %b", tag, cyc, dmem_req, e_req);
      end
      tests_run++;
      if (lsu_done !== e_done) begin
        tests_failed++;
        $display("FAIL %s cyc%0d lsu_done got %b exp %b", tag, cyc, lsu_done, e_done);
      end
      if (e_req) begin
        tests_run++;
        if (dmem_addr !== (addr & 32'hFFFF_FFFC) || dmem_we !== we || dmem_be !== e_be) begin
          tests_failed++;
          $display("FAIL %s cyc%0d bus addr/we/be got %h/%b/%h exp %h/%b/%h", tag, cyc,
                   dmem_addr, dmem_we, dmem_be, addr & 32'hFFFF_FFFC, we, e_be);
        end
        if (we) begin
          tests_run++;
          if (dmem_wdata !== e_wdata) begin
            tests_failed++;
            $display("FAIL %s cyc%0d dmem_wdata got %h exp %h", tag, cyc, dmem_wdata, e_wdata);
          end
        end
      end
      if (e_done) begin
        tests_run++;
        if (load_data !== e_load || bus_err !== timed_out || misalign !== trap) begin
          tests_failed++;
          $display("FAIL %s result load_data/bus_err/misalign got %h/%b/%b exp %h/%b/%b", tag,
                   load_data, bus_err, misalign, e_load, timed_out, trap);
        end
      end
      @(posedge clk); #1;
    end

    MemReqM    = 1'b0;
    dmem_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (dmem_req !== 1'b0 || lsu_done !== 1'b0 || StallM !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s after-done req/done/stall got %b/%b/%b exp 0/0/0", tag, dmem_req, lsu_done, StallM);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    tests_run++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== 32'h0 || dmem_be !== 4'h0 ||
        dmem_wdata !== 32'h0 || lsu_done !== 1'b0 || load_data !== 32'h0 || bus_err !== 1'b0 ||
        misalign !== 1'b0 || StallM !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s outputs req=%b we=%b addr=%h be=%h wdata=%h done=%b ld=%h err=%b mis=%b stall=%b exp all 0",
               tag, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, lsu_done, load_data, bus_err,
               misalign, StallM);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; MemReqM = 1'b0; MemWriteM = 1'b0; funct3M = 3'd0;
    ALUResultM = 32'h0; WriteDataM = 32'h0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_idle_ready();
    for (int i = 0; i < 4; i++) begin
      dmem_ready = 1'b1;
      dmem_rdata = $urandom;
      @(negedge clk);
      check_all_zero("idle_ready");
      @(posedge clk); #1;
    end
    dmem_ready = 1'b0;
  endtask

  task automatic test_directed();
    do_access("lw_0x100",  1'b0, 3'd2, 32'h100, 32'h0,        0, 32'hDEADBEEF);
    do_access("lb_0x203",  1'b0, 3'd0, 32'h203, 32'h0,        3, 32'h80123456);
    do_access("lbu_0x203", 1'b0, 3'd4, 32'h203, 32'h0,        3, 32'h80123456);
    do_access("lh_0x102",  1'b0, 3'd1, 32'h102, 32'h0,        1, 32'h9ABC1234);
    do_access("lhu_0x102", 1'b0, 3'd5, 32'h102, 32'h0,        2, 32'h9ABC1234);
    do_access("sh_0x102",  1'b1, 3'd1, 32'h102, 32'h1234ABCD, 0, 32'h0);
    do_access("sb_0x001",  1'b1, 3'd0, 32'h001, 32'h000000AA, 1, 32'h0);
    do_access("sw_0x44",   1'b1, 3'd2, 32'h044, 32'hCAFEF00D, 4, 32'h0);
    do_access("ld_bad_f3", 1'b0, 3'd3, 32'h048, 32'h0,        0, 32'hFFFFFFFF);
  endtask

  task automatic test_timeout();
    do_access("lw_timeout",   1'b0, 3'd2, 32'h040, 32'h0,        TIMEOUT,     32'h55AA55AA);
    do_access("sw_timeout",   1'b1, 3'd2, 32'h080, 32'h01020304, TIMEOUT + 3, 32'h0);
    do_access("lw_last_slot", 1'b0, 3'd2, 32'h0C0, 32'h0,        TIMEOUT - 1, 32'h13579BDF);
  endtask

  task automatic test_misalign();
    do_access("lw_0x102",  1'b0, 3'd2, 32'h102, 32'h0,        0, 32'hA5A5F00F);
    do_access("lhu_0x103", 1'b0, 3'd5, 32'h103, 32'h0,        1, 32'h8765C321);
    do_access("sh_0x001",  1'b1, 3'd1, 32'h001, 32'h0000BEEF, 0, 32'h0);
    do_access("sw_0x003",  1'b1, 3'd2, 32'h003, 32'h11223344, 2, 32'h0);
  endtask

  task automatic test_reset_mid();
    MemReqM = 1'b1; MemWriteM = 1'b0; funct3M = 3'd2; ALUResultM = 32'h300; dmem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (dmem_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid busy dmem_req got %b exp 1", dmem_req);
    end
    @(posedge clk); #1;
    rst_n = 1'b0; dmem_ready = 1'b1; dmem_rdata = 32'h12345678; MemReqM = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    check_all_zero("reset_mid");
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("reset_mid_idle");
    @(posedge clk); #1;
    do_access("lw_after_rst", 1'b0, 3'd2, 32'h300, 32'h0, 1, 32'h0BADF00D);
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic        we;
    int          waits;
    logic [2:0]  load_ops[8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd6};
    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = we ? 3'($urandom_range(0, 2)) : load_ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) waits = $urandom_range(TIMEOUT - 1, TIMEOUT + 2);
      else                           waits = $urandom_range(0, 5);
      do_access($sformatf("rand%0d", i), we, f3, $urandom, $urandom, waits, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_idle_ready();
    test_directed();
    test_timeout();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer for the MEM stage of the RV32I pipeline. It converts a MEM-stage memory request into a single word-aligned transaction on a variable-latency data-memory port, holding the pipeline until that transaction completes. For stores it generates byte enables and lane-replicated write data. For loads it captures the raw read word and drives the existing load-extension datapath (funct3 and byte offset), returning the sign- or zero-extended result.

## Interface
Parameters:
- TIMEOUT, default 16: BUSY cycles without `dmem_ready` before the access is aborted with a bus error. Legal range 2..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- MemReqM  in  1  MEM-stage instruction is a load or store.
- MemWriteM  in  1  1 = store, 0 = load.
- funct3M  in  3  RV32I load/store funct3.
- ALUResultM  in  32  effective byte address.
- WriteDataM  in  32  store data, rs2.
- dmem_req  out  1  bus request; registered.
- dmem_we  out  1  write strobe; registered.
- dmem_addr  out  32  word address, `{ALUResultM[31:2], 2'b00}`; registered.
- dmem_be  out  4  byte enables; registered.
- dmem_wdata  out  32  lane-replicated store data; registered.
- dmem_ready  in  1  transaction complete; `dmem_rdata` valid in the same cycle.
- dmem_rdata  in  32  read word.
- StallM  out  1  freeze IF/ID/EX/M.
- lsu_done  out  1  one-cycle completion pulse.
- load_data  out  32  extended load result; valid while `lsu_done`=1.
- bus_err  out  1  timeout flag; valid while `lsu_done`=1.
- misalign  out  1  misaligned-access flag; valid while `lsu_done`=1. Tied to 0 when the trap is compiled out.

## Operation
States: IDLE, BUSY, DONE. Reset forces IDLE.

IDLE:
- On `MemReqM`=1 (and no trap), register the `dmem_*` outputs with `dmem_req`=1, latch `funct3M` and `ALUResultM[1:0]`, clear the timeout counter, and go to BUSY.

BUSY:
- Hold all `dmem_*` outputs stable.
- On `dmem_ready`=1: capture `dmem_rdata` (loads only), drop `dmem_req`, go to DONE.
- Otherwise increment the counter. When it reaches TIMEOUT-1 with no ready: drop `dmem_req`, set `bus_err`, force captured data to 0, go to DONE.

DONE:
- `lsu_done`=1.
- Go to IDLE unconditionally. `MemReqM` is still high for the same instruction this cycle and must not re-issue.

Store encoding (off = `ALUResultM[1:0]`):
- sb: be = `4'b0001 << off`, wdata = `{4{WriteDataM[7:0]}}`.
- sh: be = `4'b0011 << {off[1],1'b0}`, wdata = `{2{WriteDataM[15:0]}}`.
- sw: be = `4'b1111`, wdata = `WriteDataM`.

Load encoding:
- `dmem_be`=`4'b1111`, `dmem_we`=0.
- `load_data` = loadext(latched funct3, latched off, captured word). lb/lbu/lh/lhu/lw follow the standard lane select with sign or zero extension.
- Unsupported funct3 yields 0.

Store result:
- For stores, `load_data`=0 in DONE.

Reset mid-operation:
- The next edge forces IDLE.
- Every output returns to its reset value.
- An in-flight `dmem_ready` is ignored.

## Timing
- Reset values: `dmem_req`/`dmem_we`=0, `dmem_addr`/`dmem_wdata`=0, `dmem_be`=0, `lsu_done`/`bus_err`/`misalign`=0, `load_data`=0, counter=0.
- StallM = (IDLE & `MemReqM` & !trap) | BUSY. Combinational. Low in DONE, so the pipeline advances at the end of DONE.
- Zero-wait memory (`dmem_ready` high in the first BUSY cycle): 3 cycles, IDLE→BUSY→DONE. 2 stall cycles.
- N wait cycles: 3+N cycles.
- Timeout: DONE follows exactly TIMEOUT BUSY cycles.
- `dmem_ready` in IDLE or DONE is ignored.
- Exactly one `dmem_req` rising edge per instruction.

## Configuration
Macro `LSU_MISALIGN_TRAP_EN`.

Defined:
- In IDLE, a misaligned access goes directly to DONE with `misalign`=1, no bus request, `load_data`=0, and StallM low.
- Misaligned means lh/lhu/sh with off[0]=1, or lw/sw with off≠0.

Undefined:
- No check. Low address bits are ignored beyond the lane select: halfword uses off[1] only, word ignores off.
- `misalign` is constant 0.

## Test plan
- lw at 0x100, zero-wait, rdata=0xDEADBEEF → `dmem_addr`=0x100, `be`=0xF; `lsu_done` 2 cycles after request; `load_data`=0xDEADBEEF; StallM high for exactly 2 cycles.
- lb at 0x203, rdata=0x80123456, 3 wait cycles → `dmem_addr`=0x200; `load_data`=0xFFFFFF80; `lsu_done` on cycle 5. Repeat as lbu → 0x00000080.
- sh at 0x102 with WriteDataM=0x1234ABCD → `be`=0xC, `wdata`=0xABCDABCD, `we`=1; `load_data`=0 in DONE.
- sb at 0x001 with WriteDataM=0xAA → `be`=0x2, `wdata`=0xAAAAAAAA.
- `dmem_ready` held low, TIMEOUT=16 → `dmem_req` high for 16 cycles, then `lsu_done` with `bus_err`=1 and `load_data`=0.
- rst_n low during BUSY → next edge `dmem_req`=0 and IDLE. A following lw issues cleanly.
- With the macro defined, lw at 0x102 → no `dmem_req`; next cycle `lsu_done`=1 and `misalign`=1. Without the macro → `dmem_addr`=0x100 and the full word is returned.
